// File: rtl/rv32i_pkg.sv
// Shared types, funct3 encodings and lane helpers for the RV32I load/store unit.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // Access size comes from funct3[1:0]; the unsigned variants share the same sizes.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MASK_B;
      2'b01:   return MASK_H;
      default: return MASK_W;
    endcase
  endfunction

  // Eight-lane mask spanning the addressed word and the one after it.
  function automatic logic [7:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    return {4'b0000, size_mask(f3)} << off;
  endfunction

  // Stores only have signed-size encodings; loads also allow BU/HU.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/rv32i_lsu_if.sv
// Data-memory port: word address, lane enables, strobes and combinational read data.
interface rv32i_lsu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;

  modport master (output addr, wdata, byte_en, wr_en, rd_en, input rdata);
  modport slave  (input addr, wdata, byte_en, wr_en, rd_en, output rdata);
endinterface

// File: rtl/rv32i_lsu_align.sv
// Combinational lane alignment: store lane mask/data shift and load extract/extend.
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic [7:0]  lane,
  output logic [63:0] data,
  output logic        split,
  output logic [31:0] rdata
);

  logic [63:0] joined;
  logic [31:0] raw;

  // Store side: lanes and data shifted across a two-word window.
  always_comb begin
    lane  = lane_mask(funct3, off);
    data  = {32'b0, wdata} << {off, 3'b000};
    split = |lane[7:4];
  end

  // Load side: bring the addressed bytes down to bit 0, then extend by funct3.
  always_comb begin
    joined = {hi, lo} >> {off, 3'b000};
    raw    = joined[31:0];
    case (funct3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   rdata = {24'b0, raw[7:0]};
      F3_HU:   rdata = {16'b0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single outstanding request, optional split of misaligned accesses.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  rv32i_lsu_if.master dmem
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q, hi_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [7:0]  req_lane;
  logic        req_err;
  logic [31:0] lo_sel, hi_sel;
  logic [7:0]  lane;
  logic [63:0] data;
  logic        split;
  logic [31:0] ext_rdata;

  rv32i_lsu_align u_align (
    .funct3 (funct3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .lo     (lo_sel),
    .hi     (hi_sel),
    .lane   (lane),
    .data   (data),
    .split  (split),
    .rdata  (ext_rdata)
  );

  // Accept-time error decision so the error response needs no memory cycle.
  always_comb begin
    req_lane = lane_mask(req_funct3, req_addr[1:0]);
    req_err  = !funct3_legal(req_is_store, req_funct3) ||
               (!SPLIT_MISALIGNED && (|req_lane[7:4]));
  end

  // Feed the extractor with the word arriving this cycle so the result can be registered on entry to RESP.
  always_comb begin
    lo_sel = lo_q;
    hi_sel = hi_q;
    if (state_q == ACC0) begin
      lo_sel = dmem.rdata;
      hi_sel = '0;
    end else if (state_q == ACC1) begin
      hi_sel = dmem.rdata;
    end
  end

  // State register; reset drops straight to IDLE, which also silences the dmem strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and all handshake/memory outputs.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    dmem.addr    = '0;
    dmem.wdata   = '0;
    dmem.byte_en = '0;
    dmem.wr_en   = 1'b0;
    dmem.rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? RESP : ACC0;
      end
      ACC0: begin
        dmem.addr    = {addr_q[31:2], 2'b00};
        dmem.wdata   = data[31:0];
        dmem.byte_en = lane[3:0];
        dmem.wr_en   = store_q;
        dmem.rd_en   = !store_q;
        state_d      = split ? ACC1 : RESP;
      end
      ACC1: begin
        dmem.addr    = {addr_q[31:2] + 30'd1, 2'b00};
        dmem.wdata   = data[63:32];
        dmem.byte_en = lane[7:4];
        dmem.wr_en   = store_q;
        dmem.rd_en   = !store_q;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, load word capture and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      wdata_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            store_q  <= req_is_store;
            wdata_q  <= req_wdata;
            lo_q     <= '0;
            hi_q     <= '0;
            rdata_q  <= '0;
            err_q    <= req_err;
          end
        end
        ACC0: begin
          if (!store_q) begin
            lo_q <= dmem.rdata;
            if (!split) rdata_q <= ext_rdata;
          end
        end
        ACC1: begin
          if (!store_q) begin
            hi_q    <= dmem.rdata;
            rdata_q <= ext_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed bench for rv32i_lsu with a small byte-lane memory model behind the dmem port.
module tb_rv32i_lsu;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_is_store = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        n_req_valid = 1'b0, n_resp_ready = 1'b0;
  logic [2:0]  n_req_funct3 = 3'b0;
  logic [31:0] n_req_addr = '0;
  logic        n_req_ready, n_resp_valid, n_resp_err;
  logic [31:0] n_resp_rdata;

  rv32i_lsu_if dmem ();
  rv32i_lsu_if dmem_n ();

  rv32i_lsu #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dmem(dmem)
  );

  rv32i_lsu #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_is_store(1'b0),
    .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(32'h0),
    .resp_valid(n_resp_valid), .resp_ready(n_resp_ready), .resp_rdata(n_resp_rdata),
    .resp_err(n_resp_err), .dmem(dmem_n)
  );

  assign dmem_n.rdata = 32'hDEADBEEF;

  // Word memory: combinational read, byte-lane write on the clock edge, preload on request.
  logic [31:0] mem [0:255];
  logic        preload = 1'b0;
  assign dmem.rdata = mem[dmem.addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      mem[64] <= 32'h87654321;
      mem[65] <= 32'hAABBCCDD;
    end else if (dmem.wr_en) begin
      for (int b = 0; b < 4; b++)
        if (dmem.byte_en[b]) mem[dmem.addr[9:2]][8*b +: 8] <= dmem.wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int failures = 0;

  int          lat, acc_cnt;
  logic [31:0] acc_addr [2];
  logic [31:0] acc_wd [2];
  logic [3:0]  acc_be [2];
  logic        acc_rd [2];
  logic        acc_wr [2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic doPreload();
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
  endtask

  // Issue one request, log every memory cycle, check latency and response, hold resp_ready low for 'hold' cycles.
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int hold);
    bit done;
    @(negedge clk);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    lat = 0; acc_cnt = 0; done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acc_addr[i] = '0; acc_wd[i] = '0; acc_be[i] = '0; acc_rd[i] = 1'b0; acc_wr[i] = 1'b0;
    end
    @(posedge clk);
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (dmem.rd_en || dmem.wr_en) begin
        if (acc_cnt < 2) begin
          acc_addr[acc_cnt] = dmem.addr; acc_wd[acc_cnt] = dmem.wdata; acc_be[acc_cnt] = dmem.byte_en;
          acc_rd[acc_cnt] = dmem.rd_en; acc_wr[acc_cnt] = dmem.wr_en;
        end
        acc_cnt++;
      end
      if (resp_valid) done = 1'b1;
    end
    if (!done) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
      checkOutput({tag, "_hold_err"}, 32'(resp_err), 32'(exp_err));
      checkOutput({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({tag, "_released"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset: memory port quiet, response channel idle.
    doPreload();
    checkOutput("rst_dmem_wr", 32'(dmem.wr_en), 32'd0);
    checkOutput("rst_dmem_rd", 32'(dmem.rd_en), 32'd0);
    checkOutput("rst_dmem_be", 32'(dmem.byte_en), 32'd0);
    checkOutput("rst_dmem_addr", dmem.addr, 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);

    applyStimulus("lw100", 1'b0, F3_W, 32'h100, 32'h0, 32'h87654321, 1'b0, 2, 0);
    checkOutput("lw100_acc_cnt", 32'(acc_cnt), 32'd1);
    checkOutput("lw100_be", 32'(acc_be[0]), 32'hF);
    checkOutput("lw100_rd", 32'(acc_rd[0]), 32'd1);
    checkOutput("lw100_addr", acc_addr[0], 32'h100);

    applyStimulus("lb103", 1'b0, F3_B, 32'h103, 32'h0, 32'hFFFFFF87, 1'b0, 2, 0);
    applyStimulus("lbu103", 1'b0, F3_BU, 32'h103, 32'h0, 32'h00000087, 1'b0, 2, 0);
    applyStimulus("lh101", 1'b0, F3_H, 32'h101, 32'h0, 32'h00006543, 1'b0, 2, 0);
    checkOutput("lh101_acc_cnt", 32'(acc_cnt), 32'd1);
    checkOutput("lh101_be", 32'(acc_be[0]), 32'h6);

    applyStimulus("sh102", 1'b1, F3_H, 32'h102, 32'h00001234, 32'h0, 1'b0, 2, 0);
    checkOutput("sh102_be", 32'(acc_be[0]), 32'hC);
    checkOutput("sh102_wdata", acc_wd[0], 32'h12340000);
    checkOutput("sh102_wr", 32'(acc_wr[0]), 32'd1);
    checkOutput("sh102_rd", 32'(acc_rd[0]), 32'd0);
    applyStimulus("lw100_after_sh", 1'b0, F3_W, 32'h100, 32'h0, 32'h12344321, 1'b0, 2, 0);

    doPreload();
    applyStimulus("lw102", 1'b0, F3_W, 32'h102, 32'h0, 32'hCCDD8765, 1'b0, 3, 0);
    checkOutput("lw102_acc_cnt", 32'(acc_cnt), 32'd2);
    checkOutput("lw102_addr0", acc_addr[0], 32'h100);
    checkOutput("lw102_be0", 32'(acc_be[0]), 32'hC);
    checkOutput("lw102_addr1", acc_addr[1], 32'h104);
    checkOutput("lw102_be1", 32'(acc_be[1]), 32'h3);

    applyStimulus("sw103", 1'b1, F3_W, 32'h103, 32'h11223344, 32'h0, 1'b0, 3, 0);
    checkOutput("sw103_be0", 32'(acc_be[0]), 32'h8);
    checkOutput("sw103_wd0", acc_wd[0], 32'h44000000);
    checkOutput("sw103_be1", 32'(acc_be[1]), 32'h7);
    checkOutput("sw103_wd1", acc_wd[1], 32'h00112233);
    checkOutput("sw103_addr1", acc_addr[1], 32'h104);
    checkOutput("sw103_mem100", mem[64], 32'h44654321);
    checkOutput("sw103_mem104", mem[65], 32'hAA112233);

    applyStimulus("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0);
    checkOutput("ld_f3_011_acc_cnt", 32'(acc_cnt), 32'd0);
    applyStimulus("st_f3_011", 1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0);
    checkOutput("st_f3_011_acc_cnt", 32'(acc_cnt), 32'd0);
    checkOutput("st_f3_011_mem100", mem[64], 32'h44654321);

    applyStimulus("lw104_hold", 1'b0, F3_W, 32'h104, 32'h0, 32'hAA112233, 1'b0, 2, 5);

    // Non-splitting variant rejects a misaligned word load without touching memory.
    @(negedge clk);
    n_req_valid = 1'b1; n_req_funct3 = F3_W; n_req_addr = 32'h102; n_resp_ready = 1'b0;
    @(negedge clk);
    n_req_valid = 1'b0;
    checkOutput("nosplit_valid", 32'(n_resp_valid), 32'd1);
    checkOutput("nosplit_err", 32'(n_resp_err), 32'd1);
    checkOutput("nosplit_rdata", n_resp_rdata, 32'd0);
    checkOutput("nosplit_rd", 32'(dmem_n.rd_en), 32'd0);
    n_resp_ready = 1'b1;
    @(negedge clk);
    n_resp_ready = 1'b0;
    checkOutput("nosplit_req_ready", 32'(n_req_ready), 32'd1);

    // Reset during the second half of a split store.
    doPreload();
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h103; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_acc1_wr", 32'(dmem.wr_en), 32'd1);
    checkOutput("midrst_acc1_be", 32'(dmem.byte_en), 32'h7);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_drop", 32'(dmem.wr_en), 32'd0);
    checkOutput("midrst_be_drop", 32'(dmem.byte_en), 32'd0);
    @(negedge clk);
    checkOutput("midrst_mem104", mem[65], 32'hAABBCCDD);
    checkOutput("midrst_mem100", mem[64], 32'h44654321);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
